// File: rtl/scaler_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scaler_seq_ctrl_pkg
// Description : Shared mode codes, sequencer state encoding and frame
//               geometry for the image-scaling datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package scaler_seq_ctrl_pkg;

  // Engine selection codes (also the eng_sel mux encoding)
  localparam logic [1:0] MODE_REP = 2'b00;
  localparam logic [1:0] MODE_DEC = 2'b01;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Frame geometry: 160x120 source scaled to a 320x240 output frame
  localparam int SRC_W       = 160;
  localparam int SRC_H       = 120;
  localparam int DST_W       = 320;
  localparam int DST_H       = 240;
  localparam int FRAME_WORDS = DST_W * DST_H;

  // True for the modes that have an engine behind the mux
  function automatic logic mode_supported(input logic [1:0] m);
    return (m == MODE_REP) || (m == MODE_DEC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/scaler_seq_ctrl_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : scaler_watchdog
// Description : Run-time watchdog. Counts enabled cycles since the last
//               clear and flags when the count reaches TIMEOUT-1.
// Revision    : 1.0 - initial release
// ============================================================================
module scaler_watchdog #(
  parameter int TIMEOUT = 200000,
  parameter int TO_W    = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] r_cnt;

  // Cycle counter: clear wins over enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

  // Expiry is the final allowed cycle, so the owner exits after TIMEOUT cycles
  always_comb begin
    expired = (r_cnt == TO_W'(TIMEOUT - 1));
  end

endmodule
`default_nettype wire

// File: rtl/scaler_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : scaler_seq_ctrl
// Description : Sequencer for the scaling datapath. Clears the frame RAM to
//               the background colour, starts the selected engine, passes
//               its RAM write port through and reports completion/timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module scaler_seq_ctrl
  import scaler_seq_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = 19,
  parameter int                DATA_W    = 8,
  parameter int                CLR_WORDS = FRAME_WORDS,
  parameter logic [DATA_W-1:0] BG_COLOR  = '0,
  parameter int                TIMEOUT   = 200000,
  parameter int                TO_W      = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic              abort,
  output logic [1:0]        eng_sel,
  output logic              eng_rst,
  input  logic              eng_done,
  input  logic [ADDR_W-1:0] eng_ram_wraddr,
  input  logic [DATA_W-1:0] eng_ram_data,
  input  logic              eng_ram_wren,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic [1:0]        cur_mode,
  output logic              frame_done,
  output logic              err_mode,
  output logic              err_timeout
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [1:0]        r_mode;
  logic              r_err_mode;
  logic              r_err_timeout;
  logic              r_frame_done;

  logic              w_cmd_acc;
  logic              w_cmd_rej;
  logic              w_goto_done;
  logic              w_timeout;
  logic              w_wd_expired;
  logic              w_wd_clear;
  logic              w_wd_enable;

  // Watchdog only counts RUN cycles and restarts from zero on every entry
  assign w_wd_clear  = (r_state != S_RUN);
  assign w_wd_enable = (r_state == S_RUN);

  scaler_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_wd_clear),
    .enable  (w_wd_enable),
    .expired (w_wd_expired)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, handshake, engine control and RAM port decode
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_acc   = 1'b0;
    w_cmd_rej   = 1'b0;
    w_goto_done = 1'b0;
    w_timeout   = 1'b0;
    cmd_ready   = 1'b0;
    eng_rst     = 1'b1;
    busy        = 1'b0;
    ram_wren    = 1'b0;
    ram_wraddr  = '0;
    ram_data    = '0;

    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (mode_supported(cmd_mode)) begin
            w_cmd_acc   = 1'b1;
            w_state_nxt = S_CLEAR;
          end else begin
            w_cmd_rej = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        busy       = 1'b1;
        ram_wren   = 1'b1;
        ram_wraddr = r_clr_cnt;
        ram_data   = BG_COLOR;
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_clr_cnt == ADDR_W'(CLR_WORDS - 1)) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        // Engine stays in reset for one cycle with eng_sel already settled
        busy        = 1'b1;
        w_state_nxt = abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        busy       = 1'b1;
        eng_rst    = 1'b0;
        ram_wren   = eng_ram_wren;
        ram_wraddr = eng_ram_wraddr;
        ram_data   = eng_ram_data;
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (eng_done) begin
          w_goto_done = 1'b1;
          w_state_nxt = S_DONE;
        end else if (w_wd_expired) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        eng_rst     = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Clear address counter: runs only while clearing, otherwise parked at 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clr_cnt <= '0;
    end else if (r_state == S_CLEAR) begin
      r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
    end else begin
      r_clr_cnt <= '0;
    end
  end

  // Mode latch and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode        <= MODE_REP;
      r_err_mode    <= 1'b0;
      r_err_timeout <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_err_mode   <= w_cmd_rej;
      r_frame_done <= w_goto_done;
      if (w_cmd_acc) begin
        r_mode        <= cmd_mode;
        r_err_timeout <= 1'b0;
      end else if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end
    end
  end

  assign eng_sel     = r_mode;
  assign cur_mode    = r_mode;
  assign err_mode    = r_err_mode;
  assign err_timeout = r_err_timeout;
  assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_scaler_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_scaler_seq_ctrl
// Description : Directed testbench for scaler_seq_ctrl with a reduced clear
//               length and watchdog limit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scaler_seq_ctrl;

  localparam int         ADDR_W = 19;
  localparam int         DATA_W = 8;
  localparam int         CLR    = 16;
  localparam int         TO     = 100;
  localparam logic [7:0] BG     = 8'h3C;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_mode = 2'b00;
  logic              abort = 1'b0;
  logic [1:0]        eng_sel;
  logic              eng_rst;
  logic              eng_done = 1'b0;
  logic [ADDR_W-1:0] eng_ram_wraddr = '0;
  logic [DATA_W-1:0] eng_ram_data = '0;
  logic              eng_ram_wren = 1'b0;
  logic [ADDR_W-1:0] ram_wraddr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic              busy;
  logic [1:0]        cur_mode;
  logic              frame_done;
  logic              err_mode;
  logic              err_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  scaler_seq_ctrl #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .CLR_WORDS (CLR),
    .BG_COLOR  (BG),
    .TIMEOUT   (TO),
    .TO_W      (24)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_mode       (cmd_mode),
    .abort          (abort),
    .eng_sel        (eng_sel),
    .eng_rst        (eng_rst),
    .eng_done       (eng_done),
    .eng_ram_wraddr (eng_ram_wraddr),
    .eng_ram_data   (eng_ram_data),
    .eng_ram_wren   (eng_ram_wren),
    .ram_wraddr     (ram_wraddr),
    .ram_data       (ram_data),
    .ram_wren       (ram_wren),
    .busy           (busy),
    .cur_mode       (cur_mode),
    .frame_done     (frame_done),
    .err_mode       (err_mode),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present a command for one cycle
  task automatic issue(input logic [1:0] m);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Walk the CLEAR phase for n words (n<CLR leaves it mid-clear)
  task automatic clear_phase(input int n);
    for (int i = 0; i < n; i++) begin
      check_eq("clr_wren", ram_wren, 1);
      check_eq("clr_addr", ram_wraddr, i);
      check_eq("clr_data", ram_data, BG);
      check_eq("clr_rst", eng_rst, 1);
      if (i < n - 1 || n == CLR) tick();
    end
  endtask

  // START cycle checks, then advance into RUN
  task automatic start_phase(input logic [1:0] m);
    check_eq("start_wren", ram_wren, 0);
    check_eq("start_rst", eng_rst, 1);
    check_eq("start_sel", eng_sel, m);
    check_eq("start_busy", busy, 1);
    tick();
  endtask

  // Engine model: n RUN cycles, optional eng_done on the last one
  task automatic run_engine(input int n, input logic done, input logic [7:0] seed);
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
    logic              w;
    for (int k = 0; k < n; k++) begin
      a = ADDR_W'(k);
      d = 8'(k) ^ seed;
      w = (k % 3) != 0;
      eng_ram_wraddr = a;
      eng_ram_data   = d;
      eng_ram_wren   = w;
      eng_done       = done && (k == n - 1);
      #1;
      check_eq("run_wren", ram_wren, w);
      check_eq("run_addr", ram_wraddr, a);
      check_eq("run_data", ram_data, d);
      check_eq("run_rst", eng_rst, 0);
      check_eq("run_ready", cmd_ready, 0);
      check_eq("run_fdone", frame_done, 0);
      tick();
    end
    eng_done     = 1'b0;
    eng_ram_wren = 1'b1;
  endtask

  initial begin
    // Reset values under asynchronous reset
    #2;
    check_eq("rst_rst", eng_rst, 1);
    check_eq("rst_sel", eng_sel, 0);
    check_eq("rst_mode", cur_mode, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_wren", ram_wren, 0);
    check_eq("rst_addr", ram_wraddr, 0);
    check_eq("rst_flags", {frame_done, err_mode, err_timeout}, 0);
    tick();
    reset = 1'b0;
    tick();
    check_eq("idle_ready", cmd_ready, 1);

    // 1: replication, eng_done on the last allowed RUN cycle beats timeout
    issue(2'b00);
    check_eq("t1_ready", cmd_ready, 0);
    clear_phase(CLR);
    start_phase(2'b00);
    run_engine(TO, 1'b1, 8'h5A);
    #1;
    check_eq("t1_fdone", frame_done, 1);
    check_eq("t1_done_wren", ram_wren, 0);
    check_eq("t1_done_rst", eng_rst, 0);
    check_eq("t1_done_ready", cmd_ready, 0);
    check_eq("t1_to", err_timeout, 0);
    tick();
    eng_ram_wren = 1'b0;
    check_eq("t1_fdone_end", frame_done, 0);
    check_eq("t1_ready_end", cmd_ready, 1);
    check_eq("t1_rst_end", eng_rst, 1);

    // 2: decimation
    issue(2'b01);
    check_eq("t2_mode", cur_mode, 1);
    clear_phase(CLR);
    start_phase(2'b01);
    run_engine(25, 1'b1, 8'hC3);
    check_eq("t2_fdone", frame_done, 1);
    tick();
    eng_ram_wren = 1'b0;
    check_eq("t2_ready", cmd_ready, 1);

    // 3: unsupported mode rejected
    issue(2'b10);
    check_eq("t3_errm", err_mode, 1);
    check_eq("t3_mode", cur_mode, 1);
    check_eq("t3_sel", eng_sel, 1);
    check_eq("t3_wren", ram_wren, 0);
    check_eq("t3_ready", cmd_ready, 1);
    tick();
    check_eq("t3_errm_end", err_mode, 0);

    // 4: watchdog timeout, sticky error
    issue(2'b00);
    clear_phase(CLR);
    start_phase(2'b00);
    run_engine(TO, 1'b0, 8'h11);
    eng_ram_wren = 1'b0;
    check_eq("t4_to", err_timeout, 1);
    check_eq("t4_ready", cmd_ready, 1);
    check_eq("t4_fdone", frame_done, 0);
    check_eq("t4_rst", eng_rst, 1);
    tick();
    check_eq("t4_to_sticky", err_timeout, 1);
    issue(2'b01);
    check_eq("t4_to_clr", err_timeout, 0);

    // 5: abort mid-clear, last write at address 5
    clear_phase(5);
    tick();
    abort = 1'b1;
    check_eq("t5_addr", ram_wraddr, 5);
    check_eq("t5_wren", ram_wren, 1);
    tick();
    abort = 1'b0;
    check_eq("t5_wren_after", ram_wren, 0);
    check_eq("t5_ready", cmd_ready, 1);
    check_eq("t5_fdone", frame_done, 0);
    check_eq("t5_to", err_timeout, 0);

    // 7: abort beats eng_done in RUN
    issue(2'b00);
    clear_phase(CLR);
    start_phase(2'b00);
    run_engine(3, 1'b0, 8'h00);
    abort    = 1'b1;
    eng_done = 1'b1;
    tick();
    abort    = 1'b0;
    eng_done = 1'b0;
    check_eq("t7_ready", cmd_ready, 1);
    check_eq("t7_fdone", frame_done, 0);
    tick();
    check_eq("t7_fdone2", frame_done, 0);

    // 6: command during RUN ignored, then reset mid-RUN
    issue(2'b01);
    clear_phase(CLR);
    start_phase(2'b01);
    run_engine(4, 1'b0, 8'h77);
    cmd_valid = 1'b1;
    cmd_mode  = 2'b00;
    check_eq("t6_ready", cmd_ready, 0);
    tick();
    cmd_valid = 1'b0;
    check_eq("t6_mode", cur_mode, 1);
    check_eq("t6_busy", busy, 1);
    check_eq("t6_rst_run", eng_rst, 0);
    reset = 1'b1;
    #1;
    check_eq("t6_rst", eng_rst, 1);
    check_eq("t6_busy_rst", busy, 0);
    check_eq("t6_wren_rst", ram_wren, 0);
    check_eq("t6_mode_rst", cur_mode, 0);
    check_eq("t6_sel_rst", eng_sel, 0);
    check_eq("t6_ready_rst", cmd_ready, 1);
    tick();
    reset = 1'b0;
    eng_ram_wren = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
